fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
Instruction-fetch controller that drives the program memory. It supplies the address, absorbs the memory's one-cycle registered read latency and captures the {opcode, data} word pair. It then presents the pair to the execute stage over a valid/ready handshake. It owns the program counter and supports start, halt and handshake-qualified jumps.

Parameters:
ADDR_W, 4, program counter / memory address width
WORD_W, 4, width of opcode and data words
PC_STEP, 2, PC increment per accepted instruction (opcode word + data word)
RESET_PC, 0, PC value after reset

Ports:
clk  input  1  single clock; all state changes on the rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  level; begins fetching from the current PC when idle
halt  input  1  level; requests stop after the in-flight instruction is accepted
mem_addr  output  ADDR_W  address to program memory; registered, equals PC
mem_opcode  input  WORD_W  memory opcode output, valid one edge after mem_addr is sampled
mem_data  input  WORD_W  memory data output (word at mem_addr+1, wraps mod 2^ADDR_W)
instr_valid  output  1  instruction pair available
instr_ready  input  1  execute stage accepts the pair
instr_opcode  output  WORD_W  captured opcode
instr_data  output  WORD_W  captured data
instr_pc  output  ADDR_W  PC the pair was fetched from
jump_en  input  1  redirect PC; only honoured on a handshake
jump_addr  input  ADDR_W  redirect target
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, immediate, including mid-fetch):
  - state=IDLE, PC=mem_addr=RESET_PC, instr_pc=RESET_PC.
  - instr_valid=0, instr_opcode=0, instr_data=0, busy=0.
  - halt_pend=0.
- State IDLE:
  - If start=1 and halt=0, go to REQ. With halt=1, start is ignored.
  - Start while not IDLE is ignored.
- State REQ:
  - mem_addr=PC stable; the memory samples it at this edge. Go to WAIT.
- State WAIT:
  - Memory outputs are valid. At this edge capture mem_opcode/mem_data into instr_opcode/instr_data and set instr_pc=PC.
  - Set instr_valid=1 and go to HOLD.
- State HOLD:
  - instr_valid=1. Outputs stay frozen until the handshake (instr_valid & instr_ready).
  - On handshake: instr_valid=0 next cycle.
  - PC <= jump_en ? jump_addr : PC+PC_STEP, modulo 2^ADDR_W (14+2 -> 0).
  - Next state is IDLE if halt_pend|halt, else REQ.
- Latency and throughput:
  - instr_valid rises after the second rising edge following the edge that samples start.
  - With instr_ready held high, one instruction every 3 cycles.
- halt_pend:
  - Set whenever halt=1 in REQ/WAIT/HOLD; cleared on entry to IDLE.
  - The in-flight fetch always completes and is delivered; halt never drops a captured instruction.
- jump_en without a handshake has no effect.
- Odd jump targets are legal. The pair is then {mem[t], mem[t+1 mod 16]}, and later PCs stay odd.
- mem_addr changes only on handshake, so it is constant through REQ/WAIT/HOLD.
- Resuming after a halt continues from the updated PC (no reset to RESET_PC).
- busy=1 in REQ/WAIT/HOLD, 0 in IDLE.

Test Plan:
- Bench memory image: words 0..15 = 0,C,0,F,0,D,0,B,0,C,0,8,0,0,0,D.
- Reset then one start pulse, instr_ready=1:
  - Pairs (pc,op,data) = (0,0,C), (2,0,F), (4,0,D), (6,0,B) …, each valid 1 cycle, 3-cycle spacing.
  - First valid 2 edges after start.
- Backpressure: hold instr_ready=0 for 5 cycles at pc=2:
  - instr_valid stays 1 with op=0, data=F, pc=2 throughout; mem_addr stays 2.
  - On ready, next pair (4,0,D).
- Wrap: run to pc=14 -> pair (14,0,D); next pair is (0,0,C); mem_addr goes 14 -> 0.
- Jump:
  - jump_en=1, jump_addr=7 during handshake at pc=2 -> next pair (7,B,0), then (9,C,0).
  - jump_en pulsed while instr_ready=0 -> ignored.
- Halt:
  - Assert halt for 1 cycle during WAIT of pc=4 -> pair (4,0,D) is still delivered; then IDLE, busy=0, mem_addr=6.
  - Later start -> (6,0,B).
  - start and halt together in IDLE -> stays IDLE.
- Async reset: drop rst_n mid-HOLD (instr_valid=1) -> instr_valid, busy and the instruction outputs go 0 and mem_addr goes to 0 without a clock edge; no fetch until start.

Source files
------------

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch controller: PC, memory request, valid/ready delivery
module fetch_sequencer #(
    parameter int ADDR_W   = 4,
    parameter int WORD_W   = 4,
    parameter int PC_STEP  = 2,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              halt,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_opcode,
    input  logic [WORD_W-1:0] mem_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [WORD_W-1:0] instr_opcode,
    output logic [WORD_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic              halt_pend;

    // The PC only moves on a handshake, so the memory address is stable for a whole fetch.
    assign mem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            pc           <= PC_INIT;
            halt_pend    <= 1'b0;
            instr_valid  <= 1'b0;
            instr_opcode <= '0;
            instr_data   <= '0;
            instr_pc     <= PC_INIT;
            busy         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !halt) begin
                        state <= ST_REQ;
                        busy  <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (halt) halt_pend <= 1'b1;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (halt) halt_pend <= 1'b1;
                    instr_opcode <= mem_opcode;
                    instr_data   <= mem_data;
                    instr_pc     <= pc;
                    instr_valid  <= 1'b1;
                    state        <= ST_HOLD;
                end
                ST_HOLD: begin
                    // instr_valid is always high here, so ready alone marks the handshake.
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        pc          <= jump_en ? jump_addr : pc + STEP;
                        if (halt_pend || halt) begin
                            state     <= ST_IDLE;
                            busy      <= 1'b0;
                            halt_pend <= 1'b0;
                        end else begin
                            state <= ST_REQ;
                        end
                    end else if (halt) begin
                        halt_pend <= 1'b1;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    busy        <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
